// File: rtl/mix_columns_iter.sv
// Iterative MixColumns / InvMixColumns engine.
// A full NB-column state is loaded over a valid/ready handshake, transformed
// COLS_PER_CYCLE columns per clock in place, then offered on a second
// valid/ready handshake. The transform direction is latched per transaction.
module mix_columns_iter #(
   parameter int NB             = 4,
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [32*NB-1:0]  InData,
   input  logic              Inverse,
   input  logic              InValid,
   output logic              InReady,
   output logic [32*NB-1:0]  OutData,
   output logic              OutValid,
   input  logic              OutReady,
   output logic              Busy
);

   localparam int W  = 32 * NB;
   localparam int CW = $clog2(NB + 1);

   // Reject illegal geometries at elaboration time.
   generate
      if (NB < 4 || NB > 8 || COLS_PER_CYCLE < 1 || (NB % COLS_PER_CYCLE) != 0) begin : g_bad_param
         $error("mix_columns_iter: NB must be 4..8 and COLS_PER_CYCLE must divide NB");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mode_q, mode_d;
   logic [W-1:0]    data_q, data_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;

   logic [31:0]     col_in  [COLS_PER_CYCLE];
   logic [31:0]     col_out [COLS_PER_CYCLE];

   // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // Multiply by one of the fixed MixColumns coefficients via xtime chains.
   function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (k)
         4'h1:    gf_mul_const = b;
         4'h2:    gf_mul_const = x2;
         4'h3:    gf_mul_const = x2 ^ b;
         4'h9:    gf_mul_const = x8 ^ b;
         4'hB:    gf_mul_const = x8 ^ x2 ^ b;
         4'hD:    gf_mul_const = x8 ^ x4 ^ b;
         4'hE:    gf_mul_const = x8 ^ x4 ^ x2;
         default: gf_mul_const = 8'h00;
      endcase
   endfunction

   // Circulant column transform; byte 0 of the column sits in bits [31:24].
   function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
      logic [7:0]  a [4];
      logic [3:0]  k [4];
      logic [7:0]  b;
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         a[i] = col[31-8*i -: 8];
      end
      if (inv) begin
         k = '{4'hE, 4'hB, 4'hD, 4'h9};
      end else begin
         k = '{4'h2, 4'h3, 4'h1, 4'h1};
      end
      res = 32'h0;
      for (int i = 0; i < 4; i++) begin
         b = 8'h00;
         for (int j = 0; j < 4; j++) begin
            b = b ^ gf_mul_const(a[(i + j) % 4], k[j]);
         end
         res[31-8*i -: 8] = b;
      end
      return res;
   endfunction

   // Gather the current column group out of the row-major state and transform it.
   always_comb begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         col_in[j]  = 32'h0;
         col_out[j] = 32'h0;
      end
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         for (int r = 0; r < 4; r++) begin
            col_in[j][31-8*r -: 8] = data_q[W-1-8*(NB*r + int'(cnt_q) + j) -: 8];
         end
         col_out[j] = mix_column(col_in[j], mode_q);
      end
   end

   // Next-state, datapath update and input-ready decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      data_d  = data_q;
      InReady = 1'b0;
      case (state_q)
         S_IDLE: begin
            InReady = 1'b1;
            if (InValid) begin
               data_d  = InData;
               mode_d  = Inverse;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
               for (int r = 0; r < 4; r++) begin
                  data_d[W-1-8*(NB*r + int'(cnt_q) + j) -: 8] = col_out[j][31-8*r -: 8];
               end
            end
            cnt_d = cnt_q + CW'(COLS_PER_CYCLE);
            if (cnt_q == CW'(NB - COLS_PER_CYCLE)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (OutReady) begin
               InReady = 1'b1;
               if (InValid) begin
                  // Result consumed and next state loaded on the same edge.
                  data_d  = InData;
                  mode_d  = Inverse;
                  cnt_d   = '0;
                  state_d = S_BUSY;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      valid_d = (state_d == S_DONE);
      busy_d  = (state_d == S_BUSY);
   end

   // State, datapath and registered status flags; reset clears everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign OutData  = data_q;
   assign OutValid = valid_q;
   assign Busy     = busy_q;

endmodule
